// File: rtl/serial_stream_pkg.sv
// rtl/serial_stream_pkg.sv - shared types and constants for the serial stream front end
package serial_stream_pkg;

  // Serializer state: IDLE has nothing on the wire, SHIFT has a word in the shift register.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Level driven on the serial output when no word data is present.
  localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end with one-word holding buffer
module bit_serializer
  import serial_stream_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_en,
  output logic                     o_bit,
  output logic                     o_bit_valid,
  output logic                     o_last,
  output logic                     o_busy,
  output logic [$clog2(WIDTH)-1:0] o_bit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_cnt_last;
  logic [WIDTH-1:0] w_sr_shift;
  logic             w_out_end;

  // The holding buffer is the only thing that can refuse a word.
  assign w_accept   = i_valid && !r_hold_full;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Move the next bit toward the output end; the vacated end fills with zero.
  assign w_sr_shift = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
  assign w_out_end  = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];

  // State, shift register, counter and holding buffer all advance together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Fresh word goes straight into the shift register; hold stays empty.
          if (w_accept) begin
            r_sr    <= i_data;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (i_en && w_cnt_last) begin
            // Last bit consumed: refill from hold first, then from the input, else stop.
            if (r_hold_full) begin
              r_sr        <= r_hold;
              r_hold_full <= 1'b0;
              r_cnt       <= '0;
            end else if (w_accept) begin
              r_sr  <= i_data;
              r_cnt <= '0;
            end else begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end
          end else begin
            if (i_en) begin
              r_sr  <= w_sr_shift;
              r_cnt <= r_cnt + 1'b1;
            end
            // A word arriving mid-shift parks in hold until the current word drains.
            if (w_accept) begin
              r_hold      <= i_data;
              r_hold_full <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registers only; o_ready looks at hold_full and nothing else.
  assign o_ready     = !r_hold_full;
  assign o_bit       = (r_state == ST_SHIFT) ? w_out_end : IDLE_BIT;
  assign o_bit_valid = (r_state == ST_SHIFT);
  assign o_last      = (r_state == ST_SHIFT) && w_cnt_last;
  assign o_busy      = (r_state == ST_SHIFT) || r_hold_full;
  assign o_bit_count = r_cnt;

endmodule
